// File: rtl/cellram_async_ctrl.sv
// ---------------------------------------------------------------------------
// cellram_async_ctrl
//
// Asynchronous-mode CellularRAM / PSRAM controller. Accepts one read or write
// request at a time on a valid/ready handshake and sequences the memory pins
// through IDLE -> SETUP -> ACC -> (write: HOLD) -> RECOVER -> IDLE. Every
// memory control output is driven from a flop, so the pins never glitch.
//
// Optional feature (compile-time macro):
//   CELLRAM_WAIT_EN - once the ACC counter has expired, ACC is stretched
//                     while mt_wait=1. Without it mt_wait is ignored.
//
// Parameters:
//   ADDR_W  word-address width
//   DATA_W  data width (8 or 16), byte lanes BL = DATA_W/8
//   RD_WAIT read access cycles (1..15)
//   WR_WAIT write-enable low cycles (1..15)
//   REC_CYC recovery cycles (1..15)
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake (ready only in IDLE)
//   req_we, req_addr, req_wdata, req_be   request fields
//   rsp_valid, rsp_rdata     one-cycle completion pulse, read data (held)
//   mt_addr, mt_dq_o, mt_dq_oe, mt_dq_i   memory address and data bus
//   mt_ce_n, mt_oe_n, mt_we_n, mt_lb_n, mt_ub_n, mt_adv_n   active-low controls
//   mt_clk, mt_cre           tied low (asynchronous mode only)
//   mt_wait                  memory wait (used only with CELLRAM_WAIT_EN)
// ---------------------------------------------------------------------------
module cellram_async_ctrl #(
  parameter int ADDR_W  = 23,
  parameter int DATA_W  = 16,
  parameter int RD_WAIT = 4,
  parameter int WR_WAIT = 4,
  parameter int REC_CYC = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_be,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic [ADDR_W-1:0]     mt_addr,
  output logic [DATA_W-1:0]     mt_dq_o,
  output logic                  mt_dq_oe,
  input  logic [DATA_W-1:0]     mt_dq_i,
  output logic                  mt_ce_n,
  output logic                  mt_oe_n,
  output logic                  mt_we_n,
  output logic                  mt_lb_n,
  output logic                  mt_ub_n,
  output logic                  mt_adv_n,
  output logic                  mt_clk,
  output logic                  mt_cre,
  input  logic                  mt_wait
);

  localparam int BL = DATA_W / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACC,
    S_HOLD,
    S_RECOVER
  } state_t;

  state_t state_reg, state_next;

  logic [3:0]        cnt_reg, cnt_next;
  logic              we_reg, we_next;
  logic [BL-1:0]     be_reg, be_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;

  // Registered pin images
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] dq_o_reg, dq_o_next;
  logic              dq_oe_reg, dq_oe_next;
  logic              ce_n_reg, ce_n_next;
  logic              oe_n_reg, oe_n_next;
  logic              we_n_reg, we_n_next;
  logic              lb_n_reg, lb_n_next;
  logic              ub_n_reg, ub_n_next;
  logic              adv_n_reg, adv_n_next;
  logic              rsp_valid_reg, rsp_valid_next;
  logic [DATA_W-1:0] rdata_reg, rdata_next;

  logic              accept;
  logic              acc_done;
  logic              bus_active_next;
  logic [BL-1:0]     lane_n_next;
  logic [DATA_W-1:0] rd_masked;

  // ACC completes when its counter has run out; with wait support the
  // memory can additionally stretch it by holding mt_wait high.
`ifdef CELLRAM_WAIT_EN
  assign acc_done = (cnt_reg == 4'd0) && !mt_wait;
`else
  logic wait_unused;
  assign wait_unused = mt_wait;
  assign acc_done    = (cnt_reg == 4'd0);
`endif

  assign req_ready = (state_reg == S_IDLE);
  assign accept    = req_valid && req_ready;

  // Per-lane select and read-data masking
  generate
    for (genvar gi = 0; gi < BL; gi++) begin : g_lane
      assign lane_n_next[gi]        = ~(bus_active_next && be_next[gi]);
      assign rd_masked[gi*8 +: 8]   = be_reg[gi] ? mt_dq_i[gi*8 +: 8] : 8'h00;
    end
    if (BL > 1) begin : g_ub
      assign ub_n_next = lane_n_next[1];
    end else begin : g_no_ub
      assign ub_n_next = 1'b1;
    end
  endgenerate

  assign lb_n_next = lane_n_next[0];

  // Next-state and next pin values. Pin images are derived from the state
  // being entered so that the flopped pins line up with the state register.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;

    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          state_next = S_SETUP;
        end
      end
      S_SETUP: begin
        state_next = S_ACC;
        cnt_next   = we_reg ? 4'(WR_WAIT - 1) : 4'(RD_WAIT - 1);
      end
      S_ACC: begin
        if (acc_done) begin
          if (we_reg) begin
            state_next = S_HOLD;
          end else begin
            state_next = S_RECOVER;
            cnt_next   = 4'(REC_CYC - 1);
          end
        end else if (cnt_reg != 4'd0) begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      S_HOLD: begin
        state_next = S_RECOVER;
        cnt_next   = 4'(REC_CYC - 1);
      end
      S_RECOVER: begin
        if (cnt_reg == 4'd0) begin
          state_next = S_IDLE;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = 4'd0;
      end
    endcase

    // Request fields are captured on acceptance and held for the transaction
    we_next    = accept ? req_we    : we_reg;
    be_next    = accept ? req_be    : be_reg;
    wdata_next = accept ? req_wdata : wdata_reg;
    addr_next  = accept ? req_addr  : addr_reg;

    bus_active_next = (state_next == S_SETUP) || (state_next == S_ACC) ||
                      (state_next == S_HOLD);

    ce_n_next  = !bus_active_next;
    adv_n_next = !bus_active_next;
    oe_n_next  = !((state_next == S_ACC) && !we_next);
    // A write with no byte enabled runs the full timing without strobing WE#
    we_n_next  = !((state_next == S_ACC) && we_next && (|be_next));
    dq_oe_next = bus_active_next && we_next;
    dq_o_next  = dq_oe_next ? wdata_next : '0;

    rsp_valid_next = (state_next == S_RECOVER) && (state_reg != S_RECOVER);

    // Read data is sampled on the edge that leaves ACC and held otherwise
    rdata_next = rdata_reg;
    if ((state_reg == S_ACC) && !we_reg && acc_done) begin
      rdata_next = rd_masked;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= 4'd0;
      we_reg        <= 1'b0;
      be_reg        <= '0;
      wdata_reg     <= '0;
      addr_reg      <= '0;
      dq_o_reg      <= '0;
      dq_oe_reg     <= 1'b0;
      ce_n_reg      <= 1'b1;
      oe_n_reg      <= 1'b1;
      we_n_reg      <= 1'b1;
      lb_n_reg      <= 1'b1;
      ub_n_reg      <= 1'b1;
      adv_n_reg     <= 1'b1;
      rsp_valid_reg <= 1'b0;
      rdata_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      we_reg        <= we_next;
      be_reg        <= be_next;
      wdata_reg     <= wdata_next;
      addr_reg      <= addr_next;
      dq_o_reg      <= dq_o_next;
      dq_oe_reg     <= dq_oe_next;
      ce_n_reg      <= ce_n_next;
      oe_n_reg      <= oe_n_next;
      we_n_reg      <= we_n_next;
      lb_n_reg      <= lb_n_next;
      ub_n_reg      <= ub_n_next;
      adv_n_reg     <= adv_n_next;
      rsp_valid_reg <= rsp_valid_next;
      rdata_reg     <= rdata_next;
    end
  end

  assign mt_addr   = addr_reg;
  assign mt_dq_o   = dq_o_reg;
  assign mt_dq_oe  = dq_oe_reg;
  assign mt_ce_n   = ce_n_reg;
  assign mt_oe_n   = oe_n_reg;
  assign mt_we_n   = we_n_reg;
  assign mt_lb_n   = lb_n_reg;
  assign mt_ub_n   = ub_n_reg;
  assign mt_adv_n  = adv_n_reg;
  assign mt_clk    = 1'b0;
  assign mt_cre    = 1'b0;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rdata_reg;

endmodule

// File: tb/tb_cellram_async_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cellram_async_ctrl
//
// Self-checking bench for cellram_async_ctrl with a behavioural async SRAM
// model. Expected completions (cycle and read data) are queued when a
// request is accepted and compared when rsp_valid appears. With
// CELLRAM_WAIT_EN defined, the wait test expects 3 extra cycles.
// ---------------------------------------------------------------------------
module tb_cellram_async_ctrl;

  localparam int ADDR_W  = 23;
  localparam int DATA_W  = 16;
  localparam int RD_WAIT = 4;
  localparam int WR_WAIT = 4;
  localparam int REC_CYC = 1;
`ifdef CELLRAM_WAIT_EN
  localparam int WAIT_EXTRA = 3;
`else
  localparam int WAIT_EXTRA = 0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [1:0]        req_be;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic [ADDR_W-1:0] mt_addr;
  logic [DATA_W-1:0] mt_dq_o;
  logic              mt_dq_oe;
  logic [DATA_W-1:0] mt_dq_i;
  logic              mt_ce_n, mt_oe_n, mt_we_n, mt_lb_n, mt_ub_n, mt_adv_n;
  logic              mt_clk, mt_cre;
  logic              mt_wait;

  cellram_async_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_WAIT(RD_WAIT),
    .WR_WAIT(WR_WAIT), .REC_CYC(REC_CYC)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mt_addr(mt_addr), .mt_dq_o(mt_dq_o), .mt_dq_oe(mt_dq_oe), .mt_dq_i(mt_dq_i),
    .mt_ce_n(mt_ce_n), .mt_oe_n(mt_oe_n), .mt_we_n(mt_we_n),
    .mt_lb_n(mt_lb_n), .mt_ub_n(mt_ub_n), .mt_adv_n(mt_adv_n),
    .mt_clk(mt_clk), .mt_cre(mt_cre), .mt_wait(mt_wait)
  );

  always #5 clk = ~clk;

  // Device memory and the bench's independent expectation of its contents
  logic [15:0] dev_mem [0:1023];
  logic [15:0] exp_mem [0:1023];

  assign mt_dq_i = (!mt_ce_n && !mt_oe_n) ? dev_mem[mt_addr[9:0]] : 16'h5A5A;

  typedef struct {
    int          due;
    logic [15:0] rdata;
    bit          rd;
  } exp_t;
  exp_t sbq[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int exp_we_len = WR_WAIT;
  int exp_oe_len = RD_WAIT;
  int overlap = 0;
  bit skip_len = 1'b0;
  logic [15:0] last_rd = 16'h0000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  initial forever @(posedge clk) cyc++;

  // Device write model: lanes are written while WE# is low
  initial begin
    for (int i = 0; i < 1024; i++) begin
      dev_mem[i] = 16'h0000;
      exp_mem[i] = 16'h0000;
    end
    forever begin
      @(negedge clk);
      if (!mt_ce_n && !mt_we_n && mt_dq_oe) begin
        if (!mt_lb_n) dev_mem[mt_addr[9:0]][7:0]  = mt_dq_o[7:0];
        if (!mt_ub_n) dev_mem[mt_addr[9:0]][15:8] = mt_dq_o[15:8];
      end
    end
  end

  // Monitor: strobe lengths, OE/WE overlap and the response scoreboard
  initial begin
    int we_len;
    int oe_len;
    exp_t e;
    we_len = 0;
    oe_len = 0;
    forever begin
      @(negedge clk);
      if (!mt_oe_n && !mt_we_n) overlap++;
      if (!mt_we_n) we_len++;
      else if (we_len != 0) begin
        if (!skip_len) check("we_low_len", we_len, exp_we_len);
        we_len = 0;
      end
      if (!mt_oe_n) oe_len++;
      else if (oe_len != 0) begin
        if (!skip_len) check("oe_low_len", oe_len, exp_oe_len);
        oe_len = 0;
      end
      if (rsp_valid) begin
        if (sbq.size() == 0) begin
          check("rsp_unexpected", 1, 0);
        end else begin
          e = sbq.pop_front();
          $display("rsp %s cyc=%0d due=%0d rdata=0x%04h", e.rd ? "RD" : "WR", cyc, e.due, rsp_rdata);
          check("rsp_cycle", cyc, e.due);
          if (e.rd) begin
            check("rsp_rdata", rsp_rdata, e.rdata);
            last_rd = e.rdata;
          end else begin
            check("rdata_hold", rsp_rdata, last_rd);
          end
        end
      end else if (sbq.size() != 0 && cyc > sbq[0].due) begin
        check("rsp_missing", cyc, sbq[0].due);
        void'(sbq.pop_front());
      end
    end
  end

  // Drive one request (called at a negedge); returns the accept cycle and
  // leaves the bench at the negedge of the SETUP cycle with req_valid high.
  task automatic send(input logic we, input logic [22:0] addr, input logic [15:0] wdata,
                      input logic [1:0] be, input int extra, input bit expect_rsp,
                      output int t_acc);
    exp_t e;
    int n;
    logic [15:0] m;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("req_ready", req_ready, 1);
    t_acc = cyc;
    m = exp_mem[addr[9:0]];
    e.rd = !we;
    e.rdata = {be[1] ? m[15:8] : 8'h00, be[0] ? m[7:0] : 8'h00};
    if (we) begin
      if (be[0]) exp_mem[addr[9:0]][7:0]  = wdata[7:0];
      if (be[1]) exp_mem[addr[9:0]][15:8] = wdata[15:8];
      e.due = t_acc + 3 + WR_WAIT;
    end else begin
      exp_oe_len = RD_WAIT + extra;
      e.due = t_acc + 2 + RD_WAIT + extra;
    end
    if (expect_rsp) sbq.push_back(e);
    $display("req %s addr=0x%06h wdata=0x%04h be=%b accepted cyc=%0d",
             we ? "WR" : "RD", addr, wdata, be, t_acc);
    @(negedge clk);
    check("setup_ctl", {mt_ce_n, mt_adv_n, mt_dq_oe, mt_lb_n, mt_ub_n, mt_oe_n, mt_we_n, req_ready},
          {1'b0, 1'b0, we, ~be[0], ~be[1], 1'b1, 1'b1, 1'b0});
    check("setup_addr", mt_addr, addr);
    if (we) check("setup_dq", mt_dq_o, wdata);
  endtask

  initial begin
    int t1, t2, t3, n, we_cnt;
    logic [10:0] idle_vec;
    rst = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    req_be = 2'b00;
    mt_wait = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Idle after reset
    check("rst_addr", mt_addr, 0);
    check("rst_dq_o", mt_dq_o, 0);
    check("rst_rdata", rsp_rdata, 0);
    for (int i = 0; i < 10; i++) begin
      idle_vec = {req_ready, rsp_valid, mt_ce_n, mt_oe_n, mt_we_n, mt_lb_n, mt_ub_n,
                  mt_adv_n, mt_dq_oe, mt_clk, mt_cre};
      check("idle_ctl", idle_vec, 11'b10_111111_000);
      @(negedge clk);
    end

    // Full write, then byte-masked and full reads
    send(1'b1, 23'h000123, 16'hBEEF, 2'b11, 0, 1'b1, t1);
    req_valid = 1'b0;
    send(1'b0, 23'h000123, 16'h0000, 2'b01, 0, 1'b1, t1);
    req_valid = 1'b0;
    send(1'b0, 23'h000123, 16'h0000, 2'b11, 0, 1'b1, t1);
    req_valid = 1'b0;

    // Write with no bytes enabled: full timing, WE# never strobes
    n = 0;
    while (sbq.size() != 0 && n < 50) begin @(negedge clk); n++; end
    we_cnt = 0;
    send(1'b1, 23'h000123, 16'h1111, 2'b00, 0, 1'b1, t1);
    req_valid = 1'b0;
    for (int i = 0; i < WR_WAIT + 4; i++) begin
      if (!mt_we_n) we_cnt++;
      @(negedge clk);
    end
    check("be0_we_low", we_cnt, 0);

    // Upper-lane-only write, then read back
    send(1'b1, 23'h000123, 16'h2233, 2'b10, 0, 1'b1, t1);
    req_valid = 1'b0;
    send(1'b0, 23'h000123, 16'h0000, 2'b11, 0, 1'b1, t1);
    req_valid = 1'b0;

    // Back-to-back with req_valid held
    send(1'b1, 23'h000040, 16'hA1B2, 2'b11, 0, 1'b1, t1);
    send(1'b0, 23'h000040, 16'h0000, 2'b11, 0, 1'b1, t2);
    check("b2b_wr_rd_accept", t2, t1 + 3 + WR_WAIT + REC_CYC);
    send(1'b0, 23'h000040, 16'h0000, 2'b10, 0, 1'b1, t3);
    check("b2b_rd_rd_accept", t3, t2 + 2 + RD_WAIT + REC_CYC);
    for (int i = 0; i < 8; i++) begin
      send(1'($urandom_range(0, 1)), 23'h000300 + 23'($urandom_range(0, 7)),
           16'($urandom), 2'($urandom_range(0, 3)), 0, 1'b1, t1);
    end
    req_valid = 1'b0;

    // Read with the memory asserting wait
    n = 0;
    while (sbq.size() != 0 && n < 50) begin @(negedge clk); n++; end
    send(1'b0, 23'h000123, 16'h0000, 2'b11, WAIT_EXTRA, 1'b1, t1);
    req_valid = 1'b0;
    mt_wait = 1'b1;
    repeat (RD_WAIT + 3) @(negedge clk);
    mt_wait = 1'b0;
    n = 0;
    while (sbq.size() != 0 && n < 50) begin @(negedge clk); n++; end
    exp_oe_len = RD_WAIT;

    // Reset in the second ACC cycle of a write
    skip_len = 1'b1;
    send(1'b1, 23'h000200, 16'hCAFE, 2'b11, 0, 1'b0, t1);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ctl", {mt_we_n, mt_dq_oe, mt_ce_n, mt_oe_n, rsp_valid, req_ready}, 6'b101101);
    check("abort_rdata", rsp_rdata, 0);
    last_rd = 16'h0000;
    repeat (10) @(negedge clk);
    skip_len = 1'b0;

    // Controller still works after the abort
    send(1'b0, 23'h000040, 16'h0000, 2'b11, 0, 1'b1, t1);
    req_valid = 1'b0;

    n = 0;
    while (sbq.size() != 0 && n < 100) begin @(negedge clk); n++; end
    check("sb_drained", sbq.size(), 0);
    repeat (3) @(negedge clk);
    check("oe_we_overlap", overlap, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
